// File: rtl/bsg_flow_credit_counter_if.sv
//------------------------------------------------------------------------------
// bsg_flow_credit_counter_if
// Lane-parallel valid/ready + credit-return bundle for bsg_flow_credit_counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bsg_flow_credit_counter_if #(
   parameter int width_p = 128
);
   logic [width_p-1:0] v_i;
   logic [width_p-1:0] ready_o;
   logic [width_p-1:0] v_o;
   logic [width_p-1:0] fc_i;

   // master: the sender/consumer side driving valids and credit returns
   modport master (
      output v_i,
      output fc_i,
      input  ready_o,
      input  v_o
   );

   modport slave (
      input  v_i,
      input  fc_i,
      output ready_o,
      output v_o
   );
endinterface

`default_nettype wire

// File: rtl/bsg_flow_credit_counter.sv
//------------------------------------------------------------------------------
// bsg_flow_credit_counter
// Per-lane credit counters gating valid/ready ahead of bsg_flow_convert.
// Optional sticky overflow detection: define BSG_FLOW_CREDIT_ERR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_flow_credit_counter #(
   parameter int width_p      = 128,
   parameter int credits_p    = 8,
   parameter int start_full_p = 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   bsg_flow_credit_counter_if.slave     bus,
   output logic                         all_returned_o,
   output logic                         error_o
);

   localparam int                   c_cnt_w = $clog2(credits_p + 1);
   localparam logic [c_cnt_w-1:0]   c_max   = c_cnt_w'(credits_p);
   localparam logic [c_cnt_w-1:0]   c_one   = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0]   c_rst   = (start_full_p != 0) ? c_max : '0;

   logic [width_p-1:0] lane_ready;
   logic [width_p-1:0] lane_full;
   logic [width_p-1:0] lane_v;

   for (genvar i = 0; i < width_p; i++) begin : g_lane
      logic [c_cnt_w-1:0] cnt_q;
      logic [c_cnt_w-1:0] cnt_d;

      // Ready comes from register state only, so there is no v_i/fc_i -> ready path.
      assign lane_ready[i] = (cnt_q != '0);
      assign lane_full[i]  = (cnt_q == c_max);
      assign lane_v[i]     = bus.v_i[i] & lane_ready[i];

      always_comb begin
         cnt_d = cnt_q;
         case ({bus.fc_i[i], lane_v[i]})
            2'b10:   if (!lane_full[i]) cnt_d = cnt_q + c_one;
            2'b01:   cnt_d = cnt_q - c_one;
            default: cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) cnt_q <= c_rst;
         else         cnt_q <= cnt_d;
      end
   end

   assign bus.ready_o    = lane_ready;
   assign bus.v_o        = lane_v;
   assign all_returned_o = &lane_full;

`ifdef BSG_FLOW_CREDIT_ERR_EN
   logic [width_p-1:0] lane_ovf;
   logic               error_q;

   // A credit returned to an already-full lane means the consumer over-granted.
   assign lane_ovf = bus.fc_i & ~lane_v & lane_full;

   always_ff @(posedge clk_i) begin
      if (reset_i)        error_q <= 1'b0;
      else if (|lane_ovf) error_q <= 1'b1;
   end

   assign error_o = error_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         for (int i = 0; i < width_p; i++) begin
            if (lane_ovf[i]) $error("bsg_flow_credit_counter: credit overflow on lane %0d", i);
         end
      end
   end
`endif
`else
   assign error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_flow_credit_counter.sv
//------------------------------------------------------------------------------
// tb_bsg_flow_credit_counter
// Directed self-checking bench for bsg_flow_credit_counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_flow_credit_counter;

`ifdef BSG_FLOW_CREDIT_ERR_EN
   localparam logic c_exp_err = 1'b1;
`else
   localparam logic c_exp_err = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   logic all_ret_a, all_ret_b, all_ret_c;
   logic err_a, err_b, err_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bsg_flow_credit_counter_if #(.width_p(128)) ifa ();
   bsg_flow_credit_counter_if #(.width_p(128)) ifb ();
   bsg_flow_credit_counter_if #(.width_p(4))   ifc ();

   bsg_flow_credit_counter #(.width_p(128), .credits_p(8), .start_full_p(1)) u_dut_a (
      .clk_i(clk), .reset_i(rst_a), .bus(ifa), .all_returned_o(all_ret_a), .error_o(err_a)
   );
   bsg_flow_credit_counter #(.width_p(128), .credits_p(8), .start_full_p(0)) u_dut_b (
      .clk_i(clk), .reset_i(rst_b), .bus(ifb), .all_returned_o(all_ret_b), .error_o(err_b)
   );
   bsg_flow_credit_counter #(.width_p(4), .credits_p(1), .start_full_p(1)) u_dut_c (
      .clk_i(clk), .reset_i(rst_c), .bus(ifc), .all_returned_o(all_ret_c), .error_o(err_c)
   );

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      ifa.v_i = '0; ifa.fc_i = '0;
      ifb.v_i = '0; ifb.fc_i = '0;
      ifc.v_i = '0; ifc.fc_i = '0;
      tick;
      tick;
      #1;
      check_val("a_rdy_in_reset", ifa.ready_o, {128{1'b1}});
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      tick;

      // Reset state, start full
      #1;
      check_val("a_rst_ready", ifa.ready_o, {128{1'b1}});
      check_val("a_rst_allret", all_ret_a, 1'b1);
      check_val("a_rst_vo", ifa.v_o, '0);
      check_val("a_rst_err", err_a, 1'b0);

      // Reset state, start empty: valids must be gated off
      ifb.v_i = {128{1'b1}};
      #1;
      check_val("b_rst_ready", ifb.ready_o, '0);
      check_val("b_rst_vo", ifb.v_o, '0);
      check_val("b_rst_allret", all_ret_b, 1'b0);
      ifb.v_i = '0;

      // Lane 0 drains 8 credits over 10 held-valid cycles
      for (int k = 0; k < 10; k++) begin
         ifa.v_i = '0;
         ifa.v_i[0] = 1'b1;
         #1;
         check_val("l0_vo", ifa.v_o[0], (k < 8));
         check_val("l0_rdy", ifa.ready_o[0], (k < 8));
         check_val("l0_allret", all_ret_a, (k == 0));
         check_val("l0_other_vo", ifa.v_o[127:1], '0);
         tick;
      end
      ifa.v_i = '0;

      // Lane 5: empty, one credit back, one transfer
      for (int k = 0; k < 8; k++) begin
         ifa.v_i[5] = 1'b1;
         tick;
      end
      ifa.v_i[5] = 1'b1;
      ifa.fc_i[5] = 1'b1;
      #1;
      check_val("l5_rdy_empty", ifa.ready_o[5], 1'b0);
      check_val("l5_vo_empty", ifa.v_o[5], 1'b0);
      tick;
      ifa.fc_i[5] = 1'b0;
      #1;
      check_val("l5_rdy_after_fc", ifa.ready_o[5], 1'b1);
      check_val("l5_vo_after_fc", ifa.v_o[5], 1'b1);
      tick;
      #1;
      check_val("l5_rdy_after_xfer", ifa.ready_o[5], 1'b0);
      check_val("l5_vo_after_xfer", ifa.v_o[5], 1'b0);
      ifa.v_i[5] = 1'b0;

      // Lane 127: drop to 3, then simultaneous valid+credit for 20 cycles
      for (int k = 0; k < 5; k++) begin
         ifa.v_i[127] = 1'b1;
         tick;
      end
      ifa.fc_i[127] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         check_val("l127_vo_net0", ifa.v_o[127], 1'b1);
         tick;
      end
      ifa.fc_i[127] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val("l127_drain3", ifa.v_o[127], (k < 3));
         tick;
      end
      ifa.v_i[127] = 1'b0;

      // Lane 2: credit returned while full saturates
      ifa.fc_i[2] = 1'b1;
      #1;
      check_val("l2_err_before", err_a, 1'b0);
      tick;
      ifa.fc_i[2] = 1'b0;
      #1;
      check_val("l2_err_after", err_a, c_exp_err);
      check_val("l2_rdy", ifa.ready_o[2], 1'b1);
      for (int k = 0; k < 9; k++) begin
         ifa.v_i[2] = 1'b1;
         #1;
         check_val("l2_drain8", ifa.v_o[2], (k < 8));
         tick;
      end
      ifa.v_i[2] = 1'b0;
      #1;
      check_val("l2_err_sticky", err_a, c_exp_err);

      // Reset wins over simultaneous activity and clears the error
      rst_a = 1'b1;
      ifa.v_i = {128{1'b1}};
      ifa.fc_i = {128{1'b1}};
      tick;
      rst_a = 1'b0;
      ifa.v_i = '0;
      ifa.fc_i = '0;
      #1;
      check_val("a_rerst_ready", ifa.ready_o, {128{1'b1}});
      check_val("a_rerst_allret", all_ret_a, 1'b1);
      check_val("a_rerst_err", err_a, 1'b0);

      // DUT B: three credits on lane 1, then mid-stream reset
      ifb.fc_i[1] = 1'b1;
      tick;
      #1;
      check_val("b_l1_rdy_1", ifb.ready_o[1], 1'b1);
      tick;
      tick;
      ifb.fc_i[1] = 1'b0;
      #1;
      check_val("b_ready_3cred", ifb.ready_o, 128'h2);
      rst_b = 1'b1;
      ifb.fc_i[1] = 1'b1;
      tick;
      rst_b = 1'b0;
      ifb.fc_i[1] = 1'b0;
      ifb.v_i[1] = 1'b1;
      #1;
      check_val("b_mid_rst_ready", ifb.ready_o, '0);
      check_val("b_mid_rst_vo", ifb.v_o, '0);
      ifb.v_i[1] = 1'b0;

      // DUT C: single credit toggles ready per transfer / return
      ifc.v_i[0] = 1'b1;
      #1;
      check_val("c_vo_first", ifc.v_o, 4'h1);
      tick;
      #1;
      check_val("c_rdy_after_xfer", ifc.ready_o, 4'hE);
      check_val("c_vo_blocked", ifc.v_o, 4'h0);
      check_val("c_allret_low", all_ret_c, 1'b0);
      ifc.v_i[0] = 1'b0;
      ifc.fc_i[0] = 1'b1;
      tick;
      ifc.fc_i[0] = 1'b0;
      #1;
      check_val("c_rdy_after_fc", ifc.ready_o, 4'hF);
      check_val("c_allret_high", all_ret_c, 1'b1);
      check_val("bc_err", {err_b, err_c}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
